// File: rtl/fifo_wr_skid_if.sv
// Write-side bundle: producer valid/ready stream plus the FIFO write port.
// Handshake: a word transfers on a posedge where in_valid=1 and in_ready=1; in_data is only meaningful with in_valid.
interface fifo_wr_skid_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  full;
    logic [ADDR_WIDTH-1:0] fifo_count;

    // master: producer and FIFO side; slave: the skid block
    modport master (
        output in_valid, in_data, full, fifo_count,
        input  in_ready, wen, wdata
    );

    modport slave (
        input  in_valid, in_data, full, fifo_count,
        output in_ready, wen, wdata
    );
endinterface

// File: rtl/fifo_wr_skid.sv
// Two-entry skid buffer in front of a FIFO write port; in_ready is registered so
// FIFO full never reaches the producer combinationally.
module fifo_wr_skid #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    fifo_wr_skid_if.slave bus,
    output logic [1:0]    level,
    output logic [31:0]   wr_total
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state;
    logic                  ready_q;
    logic [DATA_WIDTH-1:0] main_data;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  accept;
    logic                  drain;
    logic [ADDR_WIDTH-1:0] unused_count;

    assign accept       = bus.in_valid & ready_q;
    assign drain        = bus.wen;
    assign bus.wen      = (state != EMPTY) & ~bus.full;
    assign bus.wdata    = main_data;
    assign bus.in_ready = ready_q;
    assign level        = state;
    assign unused_count = bus.fifo_count;

    // main_data is always the head word; skid_data only holds the second word in TWO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            ready_q   <= 1'b0;
            main_data <= '0;
            skid_data <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        state     <= ONE;
                        main_data <= bus.in_data;
                    end
                end
                ONE: begin
                    ready_q <= 1'b1;
                    if (accept && drain) begin
                        main_data <= bus.in_data;
                    end else if (accept) begin
                        state     <= TWO;
                        skid_data <= bus.in_data;
                        ready_q   <= 1'b0;
                    end else if (drain) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        state     <= ONE;
                        main_data <= skid_data;
                        ready_q   <= 1'b1;
                    end else begin
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_total <= 32'd0;
        end else if (bus.wen) begin
            wr_total <= wr_total + 32'd1;
        end
    end
endmodule

// File: tb/tb_fifo_wr_skid.sv
// Bench for fifo_wr_skid: scoreboard queue of accepted words checked against FIFO writes,
// plus per-scenario tasks for reset, streaming, backpressure, reset mid-flight and counter wrap.
module tb_fifo_wr_skid;
    localparam int DW = 8;
    localparam int AW = 5;

    logic        clk;
    logic        rst;
    logic [1:0]  level;
    logic [31:0] wr_total;

    int checks;
    int failures;
    int wen_count;
    logic [31:0] model_total;
    logic [DW-1:0] exp_q[$];

    fifo_wr_skid_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_wr_skid #(.DATA_WIDTH(DW), .FIFO_DEPTH(32), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .level    (level),
        .wr_total (wr_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after posedge; monitor samples on negedge, seeing what the next edge will use.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_total = 32'd0;
        end else begin
            checks++;
            if (bus.wen && bus.full) begin
                failures++;
                $display("FAIL wen_while_full: wen=%0b full=%0b", bus.wen, bus.full);
            end
            checks++;
            if (wr_total !== model_total) begin
                failures++;
                $display("FAIL wr_total_track: got %h expected %h", wr_total, model_total);
            end
            if (bus.wen) begin
                wen_count++;
                model_total = model_total + 32'd1;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write: wdata=%h with empty scoreboard", bus.wdata);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    if (bus.wdata !== e) begin
                        failures++;
                        $display("FAIL write_order: wdata=%h expected %h", bus.wdata, e);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus.fifo_count = AW'($urandom_range(0, 31));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        bus.full     = 1'b0;
        bus.fifo_count = '0;
        repeat (3) step();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.wen !== 1'b0 || level !== 2'd0 || wr_total !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: in_ready=%b wen=%b level=%0d wr_total=%h expected 0/0/0/0",
                     bus.in_ready, bus.wen, level, wr_total);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_edge: in_ready=%b expected 0", bus.in_ready);
        end
        step();
        checks++;
        if (bus.in_ready !== 1'b1 || level !== 2'd0) begin
            failures++;
            $display("FAIL ready_rise: in_ready=%b level=%0d expected 1/0", bus.in_ready, level);
        end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.wen !== 1'b1 || bus.wdata !== 8'hA5 || level !== 2'd1) begin
            failures++;
            $display("FAIL first_word: wen=%b wdata=%h level=%0d expected 1/a5/1", bus.wen, bus.wdata, level);
        end
        step();
        checks++;
        if (wr_total !== 32'd1 || level !== 2'd0 || bus.wen !== 1'b0) begin
            failures++;
            $display("FAIL first_total: wr_total=%h level=%0d wen=%b expected 1/0/0", wr_total, level, bus.wen);
        end
    endtask

    task automatic test_stream();
        logic [31:0] t0;
        int w0;
        t0 = wr_total;
        w0 = wen_count;
        bus.full = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(i);
            step();
            checks++;
            if (level > 2'd1 || bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL stream_level: i=%0d level=%0d in_ready=%b expected <=1/1", i, level, bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        repeat (3) step();
        checks++;
        if (wr_total - t0 !== 32'd32 || wen_count - w0 != 32 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL stream_total: writes=%0d wens=%0d pending=%0d expected 32/32/0",
                     wr_total - t0, wen_count - w0, exp_q.size());
        end
    endtask

    task automatic test_full_hold();
        bus.full = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h11;
        step();
        bus.in_data = 8'h22;
        step();
        bus.in_data = 8'h33;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (level !== 2'd2 || bus.in_ready !== 1'b0 || bus.wen !== 1'b0) begin
                failures++;
                $display("FAIL full_stall: level=%0d in_ready=%b wen=%b expected 2/0/0", level, bus.in_ready, bus.wen);
            end
        end
        bus.full = 1'b0;
        #1;
        checks++;
        if (bus.wen !== 1'b1 || bus.wdata !== 8'h11) begin
            failures++;
            $display("FAIL release_w1: wen=%b wdata=%h expected 1/11", bus.wen, bus.wdata);
        end
        step();
        checks++;
        if (bus.wen !== 1'b1 || bus.wdata !== 8'h22) begin
            failures++;
            $display("FAIL release_w2: wen=%b wdata=%h expected 1/22", bus.wen, bus.wdata);
        end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.wen !== 1'b1 || bus.wdata !== 8'h33) begin
            failures++;
            $display("FAIL release_w3: wen=%b wdata=%h expected 1/33", bus.wen, bus.wdata);
        end
        step();
        checks++;
        if (bus.wen !== 1'b0 || level !== 2'd0) begin
            failures++;
            $display("FAIL release_done: wen=%b level=%0d expected 0/0", bus.wen, level);
        end
    endtask

    task automatic test_full_toggle();
        logic [31:0] t0;
        int next;
        int cyc;
        t0 = wr_total;
        next = 1;
        cyc = 0;
        bus.full = 1'b0;
        while (next <= 20 && cyc < 200) begin
            logic acc;
            bus.in_valid = 1'b1;
            bus.in_data = DW'(next);
            bus.full = ~bus.full;
            #1;
            acc = bus.in_ready;
            step();
            cyc++;
            if (acc) next++;
            checks++;
            if (level > 2'd2) begin
                failures++;
                $display("FAIL toggle_level: level=%0d expected <=2", level);
            end
        end
        bus.in_valid = 1'b0;
        bus.full = 1'b0;
        repeat (4) step();
        checks++;
        if (next != 21 || wr_total - t0 !== 32'd20 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL toggle_total: accepted=%0d writes=%0d pending=%0d expected 20/20/0",
                     next - 1, wr_total - t0, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bus.full = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h77;
        step();
        bus.in_data = 8'h88;
        step();
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (level !== 2'd2) begin
            failures++;
            $display("FAIL mid_fill: level=%0d expected 2", level);
        end
        bus.full = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.wen !== 1'b0 || level !== 2'd0 || wr_total !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset: wen=%b level=%0d wr_total=%h expected 0/0/0", bus.wen, level, wr_total);
        end
        repeat (2) step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus.wen !== 1'b0 || level !== 2'd0) begin
                failures++;
                $display("FAIL stale_word: wen=%b level=%0d expected 0/0", bus.wen, level);
            end
        end
    endtask

    task automatic test_wrap();
        force dut.wr_total = 32'hFFFF_FFFE;
        #1;
        release dut.wr_total;
        model_total = 32'hFFFF_FFFE;
        bus.full = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h5A;
        step();
        bus.in_data = 8'h5B;
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (wr_total !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL wrap_ff: wr_total=%h expected ffffffff", wr_total);
        end
        step();
        checks++;
        if (wr_total !== 32'h0000_0000) begin
            failures++;
            $display("FAIL wrap_zero: wr_total=%h expected 00000000", wr_total);
        end
        step();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        wen_count = 0;
        model_total = 32'd0;
        test_reset();
        test_stream();
        test_full_hold();
        test_full_toggle();
        test_reset_mid();
        test_wrap();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL final_drain: %0d words never written", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
